// File: rtl/turbo_perm_addr_gen_if.sv
// Bundle of the sweep request, address-ROM lookup and permuted-address output stream
// that connects turbo_perm_addr_gen to its surroundings.
interface turbo_perm_addr_gen_if #(
   parameter int A_WIDTH = 12
);
   logic               start;
   logic               mode_int_dint;
   logic [A_WIDTH-1:0] blk_len_m1;
   logic [A_WIDTH-1:0] rom_base;
   logic [A_WIDTH-1:0] rom_raddr;
   logic               rom_mode;
   logic [A_WIDTH-1:0] rom_data;
   logic               out_valid;
   logic               out_ready;
   logic [A_WIDTH-1:0] out_seq_addr;
   logic [A_WIDTH-1:0] out_perm_addr;
   logic               out_last;
   logic               busy;
   logic               done;

   modport master (
      input  start, mode_int_dint, blk_len_m1, rom_base, rom_data, out_ready,
      output rom_raddr, rom_mode, out_valid, out_seq_addr, out_perm_addr,
             out_last, busy, done
   );

   modport slave (
      output start, mode_int_dint, blk_len_m1, rom_base, rom_data, out_ready,
      input  rom_raddr, rom_mode, out_valid, out_seq_addr, out_perm_addr,
             out_last, busy, done
   );
endinterface

// File: rtl/turbo_perm_addr_gen.sv
// Sweeps natural index 0..N-1 through the interleaver/deinterleaver address ROM and
// streams each permuted address out through a single valid/ready register stage.
module turbo_perm_addr_gen #(
   parameter int A_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   n_rst,
   turbo_perm_addr_gen_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t             r_state;
   state_t             w_nextState;

   logic [A_WIDTH-1:0] r_cnt;
   logic [A_WIDTH-1:0] r_len;
   logic [A_WIDTH-1:0] r_base;
   logic               r_mode;
   logic               r_valid;
   logic               r_last;
   logic [A_WIDTH-1:0] r_seq;
   logic [A_WIDTH-1:0] r_perm;
   logic               r_done;

   logic               w_loadEn;
   logic               w_atLast;
   logic               w_latch;
   logic               w_load;
   logic               w_advance;
   logic               w_release;

   // The output register may refill in the same cycle its current word is accepted.
   assign w_loadEn = !r_valid || bus.out_ready;
   assign w_atLast = (r_cnt == r_len);

   always_comb begin
      w_nextState = r_state;
      w_latch     = 1'b0;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_latch     = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_loadEn) begin
               w_load = 1'b1;
               if (w_atLast) begin
                  w_nextState = DRAIN;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (r_valid && bus.out_ready) begin
               w_release   = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt   <= '0;
         r_len   <= '0;
         r_base  <= '0;
         r_mode  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_seq   <= '0;
         r_perm  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_release;
         if (w_latch) begin
            r_mode <= bus.mode_int_dint;
            r_len  <= bus.blk_len_m1;
            r_base <= bus.rom_base;
            r_cnt  <= '0;
         end else if (w_advance) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_load) begin
            r_perm  <= bus.rom_data;
            r_seq   <= r_cnt;
            r_last  <= w_atLast;
            r_valid <= 1'b1;
         end else if (w_release) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   // Table offset plus index wraps inside the ROM space; there is no carry out.
   assign bus.rom_raddr     = r_base + r_cnt;
   assign bus.rom_mode      = r_mode;
   assign bus.out_valid     = r_valid;
   assign bus.out_seq_addr  = r_seq;
   assign bus.out_perm_addr = r_perm;
   assign bus.out_last      = r_last;
   assign bus.busy          = (r_state != IDLE);
   assign bus.done          = r_done;

endmodule

// File: tb/tb_turbo_perm_addr_gen.sv
// Scoreboard bench for turbo_perm_addr_gen: a ROM model feeds the DUT, each start pushes
// the full expected output sequence, and a negedge monitor pops and compares it.
module tb_turbo_perm_addr_gen;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] seq;
      logic [AW-1:0] perm;
      logic          last;
   } item_t;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;

   always #5 clk = ~clk;

   turbo_perm_addr_gen_if #(.A_WIDTH(AW)) bus ();

   turbo_perm_addr_gen #(.A_WIDTH(AW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   logic [AW-1:0] intTable   [DEPTH];
   logic [AW-1:0] deintTable [DEPTH];

   // Combinational ROM: the lookup result follows the address in the same cycle.
   assign bus.rom_data = bus.rom_mode ? intTable[bus.rom_raddr] : deintTable[bus.rom_raddr];

   item_t sbQueue[$];
   item_t expItem;
   int    compared      = 0;
   int    mismatched    = 0;
   int    cycleCnt      = 0;
   int    readyMode     = 0;
   int    readyPhase    = 0;
   int    startCycle    = 0;
   int    firstOutCycle = -1;
   int    doneCycle     = -1;
   logic  expectDone    = 1'b0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cycleCnt);
      end
   endtask

   // Downstream acceptance: always ready, a 1,0,0 repeating pattern, or random.
   always @(posedge clk) begin
      #1;
      readyPhase = (readyPhase + 1) % 3;
      case (readyMode)
         1:       bus.out_ready = (readyPhase == 0);
         2:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b1;
      endcase
   end

   // Monitor: every presented word must be the scoreboard head; a handshake pops it.
   always @(negedge clk) begin
      if (n_rst) begin
         checkOutput("done", 32'(bus.done), 32'(expectDone));
         if (bus.done) begin
            doneCycle = cycleCnt;
            checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
         end
         expectDone = 1'b0;
         if (bus.out_valid) begin
            if (sbQueue.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_output: got seq 0x%0h, expected no output",
                        bus.out_seq_addr);
            end else begin
               expItem = sbQueue[0];
               checkOutput("seq",  32'(bus.out_seq_addr),  32'(expItem.seq));
               checkOutput("perm", 32'(bus.out_perm_addr), 32'(expItem.perm));
               checkOutput("last", 32'(bus.out_last),      32'(expItem.last));
               if (bus.out_ready) begin
                  void'(sbQueue.pop_front());
                  if (expItem.seq == '0) firstOutCycle = cycleCnt;
                  expectDone = expItem.last;
               end
            end
         end
      end
   end

   task automatic waitIdle();
      int guard = 0;
      while (bus.busy && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (bus.busy) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL idle_timeout: got busy=1, expected 0 within 5000 cycles");
      end
   endtask

   task automatic applyStimulus(input logic mode, input logic [AW-1:0] base,
                                input logic [AW-1:0] lenM1);
      item_t         it;
      logic [AW-1:0] addr;
      waitIdle();
      bus.mode_int_dint = mode;
      bus.rom_base      = base;
      bus.blk_len_m1    = lenM1;
      bus.start         = 1'b1;
      startCycle        = cycleCnt;
      firstOutCycle     = -1;
      doneCycle         = -1;
      for (int k = 0; k <= int'(lenM1); k++) begin
         addr    = base + AW'(k);
         it.seq  = AW'(k);
         it.perm = mode ? intTable[addr] : deintTable[addr];
         it.last = (k == int'(lenM1));
         sbQueue.push_back(it);
      end
      @(posedge clk);
      #1;
      bus.start         = 1'b0;
      bus.mode_int_dint = ~mode;
      bus.rom_base      = AW'($urandom);
      bus.blk_len_m1    = AW'($urandom);
      checkOutput("busy_run",  32'(bus.busy),      32'd1);
      checkOutput("raddr_k0",  32'(bus.rom_raddr), 32'(base));
      checkOutput("rom_mode",  32'(bus.rom_mode),  32'(mode));
   endtask

   task automatic waitSweepDone();
      int guard = 0;
      while ((sbQueue.size() != 0 || bus.busy) && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (sbQueue.size() != 0 || bus.busy) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL sweep_timeout: got %0d outputs pending, expected 0", sbQueue.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 50000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      for (int i = 0; i < DEPTH; i++) begin
         intTable[i]   = AW'(i) ^ AW'(5);
         deintTable[i] = AW'($urandom);
      end
      bus.start         = 1'b0;
      bus.mode_int_dint = 1'b0;
      bus.rom_base      = '0;
      bus.blk_len_m1    = '0;
      bus.out_ready     = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_raddr", 32'(bus.rom_raddr),     32'd0);
      checkOutput("rst_mode",  32'(bus.rom_mode),      32'd0);
      checkOutput("rst_valid", 32'(bus.out_valid),     32'd0);
      checkOutput("rst_seq",   32'(bus.out_seq_addr),  32'd0);
      checkOutput("rst_perm",  32'(bus.out_perm_addr), 32'd0);
      checkOutput("rst_last",  32'(bus.out_last),      32'd0);
      checkOutput("rst_busy",  32'(bus.busy),          32'd0);
      checkOutput("rst_done",  32'(bus.done),          32'd0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      readyMode = 0;
      applyStimulus(1'b1, 12'h000, 12'd7);
      waitSweepDone();
      checkOutput("basic_first_latency", 32'(firstOutCycle - startCycle), 32'd2);
      checkOutput("basic_done_latency",  32'(doneCycle - startCycle),     32'd10);

      applyStimulus(1'b0, 12'h100, 12'd3);
      waitSweepDone();

      readyMode = 1;
      applyStimulus(1'b1, AW'($urandom), 12'd7);
      waitSweepDone();

      readyMode = 0;
      applyStimulus(1'b1, 12'h0A0, 12'd0);
      waitSweepDone();
      checkOutput("len1_first_latency", 32'(firstOutCycle - startCycle), 32'd2);
      checkOutput("len1_done_latency",  32'(doneCycle - startCycle),     32'd3);

      applyStimulus(1'b0, 12'hFFE, 12'd3);
      waitSweepDone();

      applyStimulus(1'b1, 12'h200, 12'd15);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      bus.mode_int_dint = 1'b0;
      bus.rom_base      = 12'h7C0;
      bus.blk_len_m1    = 12'd3;
      bus.start         = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      waitSweepDone();
      checkOutput("busy_start_done_latency", 32'(doneCycle - startCycle), 32'd18);

      applyStimulus(1'b1, 12'h300, 12'd15);
      guard = 0;
      while (!(bus.out_valid && bus.out_seq_addr == 12'd5) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("reach_k5", 32'(bus.out_seq_addr), 32'd5);
      #1;
      n_rst = 1'b0;
      sbQueue.delete();
      expectDone = 1'b0;
      #1;
      checkOutput("mid_rst_raddr", 32'(bus.rom_raddr),     32'd0);
      checkOutput("mid_rst_valid", 32'(bus.out_valid),     32'd0);
      checkOutput("mid_rst_seq",   32'(bus.out_seq_addr),  32'd0);
      checkOutput("mid_rst_perm",  32'(bus.out_perm_addr), 32'd0);
      checkOutput("mid_rst_last",  32'(bus.out_last),      32'd0);
      checkOutput("mid_rst_busy",  32'(bus.busy),          32'd0);
      checkOutput("mid_rst_done",  32'(bus.done),          32'd0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b0, 12'h010, 12'd5);
      waitSweepDone();

      readyMode = 2;
      for (int s = 0; s < 20; s++) begin
         applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom_range(0, 40)));
      end
      waitSweepDone();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/turbo_perm_addr_gen.md
# turbo_perm_addr_gen

Permutation address sequencer for the turbo interleaver/deinterleaver path. On a start pulse it sweeps a natural index 0..N-1, presents base+index to the interleaver/deinterleaver address ROM (combinational lookup, mode-selected), and registers each looked-up permuted address into a valid/ready output stream for the extrinsic-memory read/write stage downstream. The block sits directly upstream of the address ROM and is the ROM's only driver.

## Interface
- A_WIDTH, 12, width of ROM address, natural index, and permuted address; ROM depth is 2**A_WIDTH

- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- mode_int_dint  in  1  1 = interleave table, 0 = deinterleave table; latched at start
- blk_len_m1  in  A_WIDTH  block length minus one (N-1); latched at start
- rom_base  in  A_WIDTH  table offset for the selected block size; latched at start
- rom_raddr  out  A_WIDTH  address to ROM
- rom_mode  out  1  latched mode_int_dint to ROM select
- rom_data  in  A_WIDTH  ROM lookup result, valid in the same cycle as rom_raddr
- out_valid  out  1  output stream valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_seq_addr  out  A_WIDTH  natural index k of current output
- out_perm_addr  out  A_WIDTH  permuted address for index k
- out_last  out  1  high on the output with k = N-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last output is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on start=1, latch mode, blk_len_m1, rom_base into len_q/base_q/mode_q; clear cnt to 0; go RUN. start is ignored in RUN/DRAIN.
- rom_raddr = base_q + cnt, modulo 2**A_WIDTH (wrap, no carry out). rom_mode = mode_q.
- load_en = !out_valid || out_ready (single output register, full throughput).
- RUN, load_en=1: out_perm_addr <= rom_data, out_seq_addr <= cnt, out_last <= (cnt == len_q), out_valid <= 1. If cnt == len_q go DRAIN and hold cnt; else cnt <= cnt+1.
- RUN, load_en=0: all registers hold; rom_raddr stays stable.
- DRAIN: on out_valid && out_ready (necessarily out_last): out_valid <= 0, out_last <= 0, done <= 1, go IDLE.
- Outside DRAIN exit, out_valid clears only via handshake with no reload.
- blk_len_m1 = 0: exactly one output, out_last=1 on it.
- Input changes to mode/len/base after start have no effect until next start.
- n_rst low at any time: immediate return to IDLE, sweep abandoned, no done.

## Timing
- Reset values: rom_raddr 0, rom_mode 0, out_valid 0, out_seq_addr 0, out_perm_addr 0, out_last 0, busy 0, done 0; cnt, len_q, base_q, mode_q 0.
- Cycle 0 start sampled; cycle 1 RUN, busy=1, rom_raddr=base; cycle 2 out_valid=1 with k=0. Start-to-first-output latency 2 cycles.
- With out_ready held 1: one output per cycle, k=N-1 in cycle N+1, done=1 and busy=0 in cycle N+2.
- Each cycle out_ready=0 while out_valid=1 adds exactly one cycle; no output is dropped or duplicated.
- done is a registered pulse, exactly one cycle; a start in the done cycle is accepted (state is IDLE).

## Test plan
- Reset: drive n_rst=0 mid-sweep (k=5 of N=16) -> all outputs 0 same cycle, busy=0, no done; next start restarts at k=0.
- Basic interleave: ROM holds rom[i]=i^0x5, start with mode=1, base=0, len_m1=7, ready=1 -> out_valid cycles 2..9, perm 5,4,7,6,1,0,3,2, last only on k=7, done in cycle 10.
- Mode/base: mode=0, base=0x100, len_m1=3 -> rom_raddr 0x100..0x103, rom_mode=0, seq 0..3 with matching ROM values.
- Backpressure: N=8, out_ready toggled 1,0,0,1,... -> each k appears once, held stable while ready=0, done one cycle after last handshake.
- Boundaries: len_m1=0 -> single output k=0 with last=1, done in cycle 3; base=0xFFE, len_m1=3 -> rom_raddr 0xFFE,0xFFF,0x000,0x001.
- Busy start: pulse start at cycle 4 of an N=16 sweep with different len -> ignored, sweep completes with original 16 outputs.
